// File: rtl/sram_sp_pipe_if.sv
// sram_sp_pipe bus: request, read-return and status signals.
// Parity signals exist only when SRAM_PARITY_EN is defined.
interface sram_sp_pipe_if #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
);
    localparam int NB = WIDTH / 8;
    localparam int AW = $clog2(DEPTH);

    logic             ce_b;
    logic             we_b;
    logic [NB-1:0]    be;
    logic [AW-1:0]    addr_in;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             init_busy;
`ifdef SRAM_PARITY_EN
    logic             par_err;
    logic             inj_par;

    modport master (
        output ce_b, we_b, be, addr_in, data_in, inj_par,
        input  data_out, rd_valid, init_busy, par_err
    );
    modport slave (
        input  ce_b, we_b, be, addr_in, data_in, inj_par,
        output data_out, rd_valid, init_busy, par_err
    );
`else
    modport master (
        output ce_b, we_b, be, addr_in, data_in,
        input  data_out, rd_valid, init_busy
    );
    modport slave (
        input  ce_b, we_b, be, addr_in, data_in,
        output data_out, rd_valid, init_busy
    );
`endif
endinterface

// File: rtl/sram_sp_pipe.sv
// Single-port SRAM with byte enables, RD_LAT read pipeline and
// post-reset clear sequencer. Optional lane parity: SRAM_PARITY_EN.
module sram_sp_pipe #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rstb,
    sram_sp_pipe_if.slave  bus
);
    localparam int NB = WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RST,
        ST_INIT,
        ST_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;

    logic            busy;
    logic            clr_en;
    logic            acc;
    logic            addr_ok;
    logic            rd_acc;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [NB-1:0]   wr_be;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_word;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [RD_LAT:0]            vld_q, vld_d;
    logic [RD_LAT:0][WIDTH-1:0] dat_q, dat_d;

`ifdef SRAM_PARITY_EN
    logic [NB-1:0]   par_q [DEPTH];
    logic [NB-1:0]   wr_par;
    logic [NB-1:0]   rd_par_calc;
    logic [NB-1:0]   rd_par_stored;
    logic [RD_LAT:0] err_q, err_d;
`endif

    // Clear sequencer: RST and INIT both sweep mem[cnt] to zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        unique case (state_q)
            ST_RST, ST_INIT: begin
                clr_en = !rstb;
                if (cnt_q == LAST_A) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_INIT;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Request qualification and write-port selection
    always_comb begin
        busy    = (state_q != ST_RUN);
        acc     = !bus.ce_b && !busy && !rstb;
        addr_ok = ({1'b0, bus.addr_in} < DEPTH_W);
        rd_acc  = acc && bus.we_b;
        rd_word = addr_ok ? mem_q[bus.addr_in] : '0;
        wr_en   = clr_en || (acc && !bus.we_b && addr_ok);
        wr_addr = clr_en ? cnt_q : bus.addr_in;
        wr_be   = clr_en ? '1 : bus.be;
        wr_data = clr_en ? '0 : bus.data_in;
    end

`ifdef SRAM_PARITY_EN
    // Lane parity for writes and read check
    always_comb begin
        rd_par_stored = addr_ok ? par_q[bus.addr_in] : '0;
        for (int i = 0; i < NB; i++) begin
            wr_par[i]      = clr_en ? 1'b0
                           : (^bus.data_in[8*i +: 8]) ^ bus.inj_par;
            rd_par_calc[i] = ^rd_word[8*i +: 8];
        end
    end
`endif

    // Storage array, byte-lane writes
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
`ifdef SRAM_PARITY_EN
                    par_q[wr_addr][i] <= wr_par[i];
`endif
                end
            end
        end
    end

    // Read pipeline; data stages hold when no valid moves in
    always_comb begin
        vld_d = {vld_q[RD_LAT-1:0], rd_acc};
        dat_d = dat_q;
        if (rd_acc) begin
            dat_d[0] = rd_word;
        end
        for (int k = 1; k <= RD_LAT; k++) begin
            if (vld_q[k-1]) begin
                dat_d[k] = dat_q[k-1];
            end
        end
`ifdef SRAM_PARITY_EN
        err_d    = {err_q[RD_LAT-1:0], 1'b0};
        err_d[0] = rd_acc && addr_ok && (rd_par_calc != rd_par_stored);
`endif
    end

    // State, counter and pipeline registers
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            vld_q   <= '0;
            dat_q   <= '0;
`ifdef SRAM_PARITY_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
`ifdef SRAM_PARITY_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.data_out  = dat_q[RD_LAT];
    assign bus.rd_valid  = vld_q[RD_LAT];
    assign bus.init_busy = busy;
`ifdef SRAM_PARITY_EN
    assign bus.par_err   = vld_q[RD_LAT] && err_q[RD_LAT];
`endif

endmodule

// File: tb/tb_sram_sp_pipe.sv
// Bench for sram_sp_pipe: two instances (16x32 lat3, 12x32 lat1)
// driven in lockstep and checked against a word/queue model.
module tb_sram_sp_pipe;
    logic        clk = 1'b0;
    logic        rstb;
    logic        ce_b, we_b, inj;
    logic [3:0]  be, addr;
    logic [31:0] din;

    always #5 clk = ~clk;

    sram_sp_pipe_if #(.DEPTH(16), .WIDTH(32)) ifa ();
    sram_sp_pipe_if #(.DEPTH(12), .WIDTH(32)) ifb ();

    assign ifa.ce_b = ce_b;    assign ifb.ce_b = ce_b;
    assign ifa.we_b = we_b;    assign ifb.we_b = we_b;
    assign ifa.be = be;        assign ifb.be = be;
    assign ifa.addr_in = addr; assign ifb.addr_in = addr;
    assign ifa.data_in = din;  assign ifb.data_in = din;
`ifdef SRAM_PARITY_EN
    assign ifa.inj_par = inj;  assign ifb.inj_par = inj;
`endif

    sram_sp_pipe #(.DEPTH(16), .WIDTH(32), .RD_LAT(3)) dut_a (
        .clk(clk), .rstb(rstb), .bus(ifa)
    );
    sram_sp_pipe #(.DEPTH(12), .WIDTH(32), .RD_LAT(1)) dut_b (
        .clk(clk), .rstb(rstb), .bus(ifb)
    );

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } rd_t;

    localparam int DEP [2] = '{16, 12};
    localparam int LAT [2] = '{3, 1};

    rd_t         rq   [2][$];
    logic [31:0] mm   [2][16];
    logic [3:0]  bad  [2][16];
    int          rem  [2];
    logic [31:0] last [2];
    int          t;
    int          checks;
    int          errors;
    logic        pre_a, pre_b;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input int k, input logic r, input logic c,
                              input logic w, input logic [3:0] b,
                              input logic [3:0] a, input logic [31:0] d,
                              input logic ij);
        rd_t x;
        if (r) begin
            rq[k].delete();
            rem[k]  = DEP[k];
            last[k] = '0;
            for (int i = 0; i < 16; i++) begin
                mm[k][i]  = '0;
                bad[k][i] = '0;
            end
        end else if (rem[k] > 0) begin
            rem[k]--;
        end else if (!c) begin
            if (w) begin
                x.due = t + LAT[k];
                x.d   = (int'(a) < DEP[k]) ? mm[k][a] : 32'h0;
                x.e   = (int'(a) < DEP[k]) && (bad[k][a] != 4'h0);
                rq[k].push_back(x);
            end else if (int'(a) < DEP[k]) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) begin
                        mm[k][a][8*i +: 8] = d[8*i +: 8];
                        bad[k][a][i]       = ij;
                    end
                end
            end
        end
    endtask

    task automatic compare(input int k, input logic r, input logic ov,
                           input logic [31:0] od, input logic ob,
                           input logic oe);
        logic ev, ee;
        ev = 1'b0;
        ee = 1'b0;
        if (rq[k].size() > 0 && rq[k][0].due == t) begin
            ev      = 1'b1;
            ee      = rq[k][0].e;
            last[k] = rq[k][0].d;
            void'(rq[k].pop_front());
        end
        chk($sformatf("i%0d.rd_valid t%0d", k, t), 32'(ov), 32'(ev));
        chk($sformatf("i%0d.data_out t%0d", k, t), od, last[k]);
        chk($sformatf("i%0d.init_busy t%0d", k, t), 32'(ob),
            32'(r || rem[k] > 0));
`ifdef SRAM_PARITY_EN
        chk($sformatf("i%0d.par_err t%0d", k, t), 32'(oe), 32'(ev && ee));
`else
        if (oe) chk($sformatf("i%0d.par_stub", k), 32'(oe), 32'(ee));
`endif
    endtask

    task automatic cyc(input logic r, input logic c, input logic w,
                       input logic [3:0] b, input logic [3:0] a,
                       input logic [31:0] d, input logic ij);
        logic oea, oeb;
        rstb = r; ce_b = c; we_b = w; be = b; addr = a; din = d; inj = ij;
        pre_a = ifa.init_busy;
        pre_b = ifb.init_busy;
        @(posedge clk);
        t++;
        model_edge(0, r, c, w, b, a, d, ij);
        model_edge(1, r, c, w, b, a, d, ij);
        #1;
`ifdef SRAM_PARITY_EN
        oea = ifa.par_err;
        oeb = ifb.par_err;
`else
        oea = 1'b0;
        oeb = 1'b0;
`endif
        compare(0, r, ifa.rd_valid, ifa.data_out, ifa.init_busy, oea);
        compare(1, r, ifb.rd_valid, ifb.data_out, ifb.init_busy, oeb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 1, 4'h0, 4'h0, 32'h0, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic ij);
        cyc(0, 0, 0, b, a, d, ij);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(0, 0, 1, 4'($urandom), a, 32'($urandom), 0);
    endtask

    initial begin
        int na, nb;
        checks = 0;
        errors = 0;
        t      = 0;
        rem    = '{16, 12};
        last   = '{32'h0, 32'h0};
        rstb = 1'b1; ce_b = 1'b1; we_b = 1'b1;
        be = '0; addr = '0; din = '0; inj = 1'b0;

        cyc(1, 1, 1, 4'h0, 4'h0, 32'h0, 0);
        cyc(1, 1, 1, 4'h0, 4'h0, 32'h0, 0);
        na = 0;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 1, 4'h0, 4'h0, 32'h0, 0);
            na += int'(pre_a);
            nb += int'(pre_b);
        end
        chk("init_len_a", 32'(na), 32'd16);
        chk("init_len_b", 32'(nb), 32'd12);

        for (int i = 0; i < 16; i++) rd(4'(i));
        idle(4);

        wr(4'd5, 32'hAABBCCDD, 4'hF, 0);
        wr(4'd5, 32'h11223344, 4'b0101, 0);
        rd(4'd5);
        idle(4);

        for (int i = 0; i < 8; i++) wr(4'(i), 32'h100 + 32'(i), 4'hF, 0);
        for (int i = 0; i < 8; i++) rd(4'(i));
        idle(5);

        wr(4'd3, 32'hDEAD_BEEF, 4'hF, 0);
        rd(4'd1);
        rd(4'd2);
        cyc(1, 1, 1, 4'h0, 4'h0, 32'h0, 0);
        wr(4'd0, 32'h55, 4'hF, 0);
        idle(20);
        rd(4'd3);
        rd(4'd0);
        idle(4);

        wr(4'd13, 32'h1234_5678, 4'hF, 0);
        rd(4'd13);
        rd(4'd11);
        idle(4);

        wr(4'd9, 32'h0102_0304, 4'hF, 0);
        wr(4'd9, 32'h0102_0304, 4'b0010, 1);
        rd(4'd9);
        rd(4'd8);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1,
                4'($urandom), 4'($urandom), 32'($urandom),
                $urandom_range(0, 7) == 0);
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
